// File: rtl/decode_ctrl_m.sv
// RV32I + M-extension decode for the ID stage, with a multi-cycle MUL/DIV sequencer
// that stalls the front end until the result is ready for writeback.
module decode_ctrl_m #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  input  logic        cmp_res,
  input  logic        flush,
  output logic        Branch,
  output logic        JALR,
  output logic        ALUSrc_A,
  output logic        ALUSrc_B,
  output logic        DatatoReg,
  output logic        RegWrite,
  output logic        mem_w,
  output logic        MIO,
  output logic        rs1use,
  output logic        rs2use,
  output logic [1:0]  hazard_optype,
  output logic [2:0]  ImmSel,
  output logic [2:0]  cmp_ctrl,
  output logic [3:0]  ALUControl,
  output logic        md_start,
  output logic        md_busy,
  output logic        md_done,
  output logic        stall,
  output logic        illegal,
  output logic [2:0]  md_op
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_AP4  = 4'd11;
  localparam logic [3:0] ALU_BOUT = 4'd12;

  localparam logic [5:0] MUL_LAT_M1 = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LAT_M1 = 6'(DIV_LAT - 1);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_inst_bits;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  // Register specifiers are consumed by the register file, not by this block.
  assign unused_inst_bits = ^{inst[24:15], inst[11:7]};

  logic is_r, is_m, is_ialu, is_load, is_store, is_branch;
  logic is_lui, is_auipc, is_jal, is_jalr;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    is_r      = 1'b0;
    is_m      = 1'b0;
    is_ialu   = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_lui    = 1'b0;
    is_auipc  = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    if (inst_valid) begin
      case (opcode)
        OP_R: begin
          if (funct7 == 7'b0000001)
            is_m = 1'b1;
          else if (funct7 == 7'b0000000 ||
                   (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
            is_r = 1'b1;
        end
        OP_IMM: begin
          case (funct3)
            3'b001:  is_ialu = (funct7 == 7'b0000000);
            3'b101:  is_ialu = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            default: is_ialu = 1'b1;
          endcase
        end
        OP_LOAD:   is_load   = !(funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
        OP_STORE:  is_store  = !funct3[2] && (funct3 != 3'b011);
        OP_BRANCH: is_branch = (funct3[2:1] != 2'b01);
        OP_LUI:    is_lui    = 1'b1;
        OP_AUIPC:  is_auipc  = 1'b1;
        OP_JAL:    is_jal    = 1'b1;
        OP_JALR:   is_jalr   = (funct3 == 3'b000);
        default:   ;
      endcase
    end
  end

  function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [2:0] cmp_code(input logic [2:0] f3);
    case (f3)
      3'b000:  return 3'd1;
      3'b001:  return 3'd2;
      3'b100:  return 3'd3;
      3'b101:  return 3'd5;
      3'b110:  return 3'd4;
      3'b111:  return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  always_comb begin
    ALUControl = 4'd0;
    if (is_r)
      ALUControl = alu_code(funct3, funct7[5]);
    else if (is_ialu)
      // For ADDI bit 30 is immediate data, so only a shift may select the alternate op.
      ALUControl = alu_code(funct3, (funct3 == 3'b101) && funct7[5]);
    else if (is_load || is_store || is_auipc)
      ALUControl = ALU_ADD;
    else if (is_jal || is_jalr)
      ALUControl = ALU_AP4;
    else if (is_lui)
      ALUControl = ALU_BOUT;
  end

  always_comb begin
    ImmSel = 3'd0;
    if (is_ialu || is_load || is_jalr) ImmSel = 3'd1;
    else if (is_branch)                ImmSel = 3'd2;
    else if (is_jal)                   ImmSel = 3'd3;
    else if (is_store)                 ImmSel = 3'd4;
    else if (is_lui || is_auipc)       ImmSel = 3'd5;
  end

  always_comb begin
    hazard_optype = 2'b00;
    if (is_r || is_ialu || is_jal || is_jalr || is_lui || is_auipc || is_m)
      hazard_optype = 2'b01;
    else if (is_load)
      hazard_optype = 2'b10;
    else if (is_store)
      hazard_optype = 2'b11;
  end

  assign cmp_ctrl  = is_branch ? cmp_code(funct3) : 3'd0;
  assign Branch    = (is_branch && cmp_res) || is_jal || is_jalr;
  assign JALR      = is_jalr;
  assign ALUSrc_A  = is_jal || is_jalr || is_auipc;
  assign ALUSrc_B  = is_ialu || is_load || is_store || is_lui || is_auipc;
  assign DatatoReg = is_load;
  assign mem_w     = is_store;
  assign MIO       = is_load || is_store;
  assign rs1use    = is_jalr || is_r || is_ialu || is_store || is_branch || is_load || is_m;
  assign rs2use    = is_r || is_store || is_branch || is_m;
  assign illegal   = inst_valid && !(is_r || is_m || is_ialu || is_load || is_store ||
                                     is_branch || is_lui || is_auipc || is_jal || is_jalr);

  // M-op writeback happens only in the DONE cycle; the decoded write enable excludes it.
  assign RegWrite  = is_r || is_ialu || is_load || is_lui || is_auipc || is_jal || is_jalr ||
                     md_done;

  state_t     state;
  logic [5:0] cnt;
  logic [2:0] op_q;

  assign md_start = (state == IDLE) && is_m && !flush && !rst;
  assign md_busy  = (state == BUSY);
  assign md_done  = (state == DONE) && !flush;
  assign stall    = md_start || md_busy;
  assign md_op    = (state == IDLE) ? (is_m ? funct3 : 3'b000) : op_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
      op_q  <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (md_start) begin
            state <= BUSY;
            cnt   <= funct3[2] ? DIV_LAT_M1 : MUL_LAT_M1;
            op_q  <= funct3;
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= 6'd0;
          end else if (cnt == 6'd0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_ctrl_m.sv
// Bench for decode_ctrl_m: directed decode/FSM scenarios plus randomized decode and
// M-op timelines, all judged against an instruction-level reference model.
module tb_decode_ctrl_m;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 32;

  logic        clk, rst, inst_valid, cmp_res, flush;
  logic [31:0] inst;
  logic        Branch, JALR, ALUSrc_A, ALUSrc_B, DatatoReg, RegWrite, mem_w, MIO;
  logic        rs1use, rs2use, md_start, md_busy, md_done, stall, illegal;
  logic [1:0]  hazard_optype;
  logic [2:0]  ImmSel, cmp_ctrl, md_op;
  logic [3:0]  ALUControl;

  int checks   = 0;
  int failures = 0;

  decode_ctrl_m #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .cmp_res(cmp_res),
    .flush(flush), .Branch(Branch), .JALR(JALR), .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B),
    .DatatoReg(DatatoReg), .RegWrite(RegWrite), .mem_w(mem_w), .MIO(MIO), .rs1use(rs1use),
    .rs2use(rs2use), .hazard_optype(hazard_optype), .ImmSel(ImmSel), .cmp_ctrl(cmp_ctrl),
    .ALUControl(ALUControl), .md_start(md_start), .md_busy(md_busy), .md_done(md_done),
    .stall(stall), .illegal(illegal), .md_op(md_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic       branch, jalr, src_a, src_b, d2r, rw, memw, mio, rs1u, rs2u, ill;
    logic [1:0] hz;
    logic [2:0] imm, cmp;
    logic [3:0] alu;
  } dec_t;

  // ALU code per funct3 (base op) and comparator code per branch funct3.
  localparam logic [3:0] ALU_F3 [8] = '{4'd1, 4'd6, 4'd8, 4'd9, 4'd5, 4'd7, 4'd4, 4'd3};
  localparam logic [2:0] CMP_F3 [8] = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd5, 3'd4, 3'd6};
  localparam logic [6:0] OPS    [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                        7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                        7'b1100111};

  localparam logic [31:0] I_ADDI = 32'h00A30293;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_MUL  = 32'h02B50533;
  localparam logic [31:0] I_DIV  = 32'h02B54533;

  function automatic dec_t model(input logic [31:0] i, input logic v, input logic c);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    d  = '0;
    f3 = i[14:12];
    f7 = i[31:25];
    if (!v) return d;
    case (i[6:0])
      7'b0110011: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
          d.alu = f7[5] ? ((f3 == 3'd0) ? 4'd2 : 4'd10) : ALU_F3[f3];
          d.rw = 1'b1; d.rs1u = 1'b1; d.rs2u = 1'b1; d.hz = 2'd1;
        end else if (f7 == 7'h01) begin
          d.rs1u = 1'b1; d.rs2u = 1'b1; d.hz = 2'd1;
        end else d.ill = 1'b1;
      end
      7'b0010011: begin
        if ((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))
          d.ill = 1'b1;
        else begin
          d.alu = (f3 == 3'd5 && f7 == 7'h20) ? 4'd10 : ALU_F3[f3];
          d.imm = 3'd1; d.src_b = 1'b1; d.rw = 1'b1; d.rs1u = 1'b1; d.hz = 2'd1;
        end
      end
      7'b0000011: begin
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) d.ill = 1'b1;
        else begin
          d.alu = 4'd1; d.imm = 3'd1; d.src_b = 1'b1; d.d2r = 1'b1; d.rw = 1'b1;
          d.mio = 1'b1; d.rs1u = 1'b1; d.hz = 2'd2;
        end
      end
      7'b0100011: begin
        if (f3 > 3'd2) d.ill = 1'b1;
        else begin
          d.alu = 4'd1; d.imm = 3'd4; d.src_b = 1'b1; d.memw = 1'b1; d.mio = 1'b1;
          d.rs1u = 1'b1; d.rs2u = 1'b1; d.hz = 2'd3;
        end
      end
      7'b1100011: begin
        if (CMP_F3[f3] == 3'd0) d.ill = 1'b1;
        else begin
          d.cmp = CMP_F3[f3]; d.imm = 3'd2; d.branch = c; d.rs1u = 1'b1; d.rs2u = 1'b1;
        end
      end
      7'b0110111: begin
        d.alu = 4'd12; d.imm = 3'd5; d.src_b = 1'b1; d.rw = 1'b1; d.hz = 2'd1;
      end
      7'b0010111: begin
        d.alu = 4'd1; d.imm = 3'd5; d.src_a = 1'b1; d.src_b = 1'b1; d.rw = 1'b1; d.hz = 2'd1;
      end
      7'b1101111: begin
        d.alu = 4'd11; d.imm = 3'd3; d.branch = 1'b1; d.src_a = 1'b1; d.rw = 1'b1; d.hz = 2'd1;
      end
      7'b1100111: begin
        if (f3 != 3'd0) d.ill = 1'b1;
        else begin
          d.alu = 4'd11; d.imm = 3'd1; d.branch = 1'b1; d.jalr = 1'b1; d.src_a = 1'b1;
          d.rw = 1'b1; d.rs1u = 1'b1; d.hz = 2'd1;
        end
      end
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h (inst=%08h)", tag, obs, exp, inst);
    end
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dec();
    dec_t e;
    e = model(inst, inst_valid, cmp_res);
    check("Branch",        32'(Branch),        32'(e.branch));
    check("JALR",          32'(JALR),          32'(e.jalr));
    check("ALUSrc_A",      32'(ALUSrc_A),      32'(e.src_a));
    check("ALUSrc_B",      32'(ALUSrc_B),      32'(e.src_b));
    check("DatatoReg",     32'(DatatoReg),     32'(e.d2r));
    check("RegWrite",      32'(RegWrite),      32'(e.rw));
    check("mem_w",         32'(mem_w),         32'(e.memw));
    check("MIO",           32'(MIO),           32'(e.mio));
    check("rs1use",        32'(rs1use),        32'(e.rs1u));
    check("rs2use",        32'(rs2use),        32'(e.rs2u));
    check("illegal",       32'(illegal),       32'(e.ill));
    check("hazard_optype", 32'(hazard_optype), 32'(e.hz));
    check("ImmSel",        32'(ImmSel),        32'(e.imm));
    check("cmp_ctrl",      32'(cmp_ctrl),      32'(e.cmp));
    check("ALUControl",    32'(ALUControl),    32'(e.alu));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".md_start"}, 32'(md_start), 32'd0);
    check({tag, ".md_busy"},  32'(md_busy),  32'd0);
    check({tag, ".md_done"},  32'(md_done),  32'd0);
    check({tag, ".stall"},    32'(stall),    32'd0);
  endtask

  // Drives one M op from its start cycle (offset k=0). f>0 flushes at offset f;
  // chg swaps the held instruction for a different M op after the start cycle.
  task automatic run_mop(input logic [31:0] i0, input int f, input bit chg, input bit tail);
    int         lat, last;
    logic [2:0] f3;
    bit         flushed;
    lat  = i0[14] ? DIV_LAT : MUL_LAT;
    last = (f != 0) ? f : lat + 1;
    f3   = i0[14:12];
    for (int k = 0; k <= last; k++) begin
      inst       = (chg && k >= 1) ? (i0 ^ 32'h0000_7000) : i0;
      inst_valid = 1'b1;
      flush      = (f != 0 && k == f);
      sample();
      flushed = (f != 0 && k >= f);
      check("mop.md_start",   32'(md_start),   32'(k == 0));
      check("mop.md_busy",    32'(md_busy),    32'(k >= 1 && k <= lat));
      check("mop.md_done",    32'(md_done),    32'(k == lat + 1 && !flushed));
      check("mop.stall",      32'(stall),      32'(k <= lat));
      check("mop.RegWrite",   32'(RegWrite),   32'(k == lat + 1 && !flushed));
      check("mop.md_op",      32'(md_op),      32'(f3));
      check("mop.ALUControl", 32'(ALUControl), 32'd0);
      advance();
    end
    flush = 1'b0;
    if (tail) begin
      inst_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
        sample();
        check_quiet("mop.idle");
        check("mop.idle.md_op", 32'(md_op), 32'd0);
        advance();
      end
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int          sel;
    w   = $urandom;
    sel = $urandom_range(0, 11);
    if (sel < 9) begin
      w[6:0] = OPS[sel];
      if (sel < 2) begin
        case ($urandom_range(0, 2))
          0:       w[31:25] = 7'h00;
          1:       w[31:25] = 7'h20;
          default: ;
        endcase
      end
    end
    if (w[6:0] == 7'b0110011 && w[31:25] == 7'h01) w[25] = 1'b0;
    return w;
  endfunction

  initial begin
    rst = 1'b1; inst = I_ADDI; inst_valid = 1'b1; cmp_res = 1'b0; flush = 1'b0;
    advance();

    // Decode stays live under reset; the sequencer does not start.
    sample();
    check("rst.ALUControl", 32'(ALUControl), 32'd1);
    check("rst.RegWrite",   32'(RegWrite),   32'd1);
    check_quiet("rst.addi");
    advance();
    inst = I_MUL;
    sample();
    check_quiet("rst.mul");
    advance();
    rst = 1'b0; inst_valid = 1'b0;
    sample();
    check_quiet("post_rst");
    check("post_rst.md_op",   32'(md_op),   32'd0);
    check("post_rst.illegal", 32'(illegal), 32'd0);
    advance();

    inst = I_ADDI; inst_valid = 1'b1;
    sample();
    check("addi.ALUControl", 32'(ALUControl),    32'd1);
    check("addi.ImmSel",     32'(ImmSel),        32'd1);
    check("addi.ALUSrc_B",   32'(ALUSrc_B),      32'd1);
    check("addi.RegWrite",   32'(RegWrite),      32'd1);
    check("addi.hazard",     32'(hazard_optype), 32'd1);
    check("addi.stall",      32'(stall),         32'd0);
    advance();

    inst = I_BNE; cmp_res = 1'b1;
    sample();
    check("bne.cmp_ctrl", 32'(cmp_ctrl), 32'd2);
    check("bne.Branch1",  32'(Branch),   32'd1);
    check("bne.rs2use",   32'(rs2use),   32'd1);
    check("bne.RegWrite", 32'(RegWrite), 32'd0);
    advance();
    cmp_res = 1'b0;
    sample();
    check("bne.Branch0", 32'(Branch), 32'd0);
    advance();

    inst = 32'hFFFF_FFFF;
    sample();
    check("ffff.illegal", 32'(illegal), 32'd1);
    check("ffff.ctrls",
          32'({Branch, JALR, ALUSrc_A, ALUSrc_B, DatatoReg, RegWrite, mem_w, MIO, rs1use,
               rs2use, hazard_optype, ImmSel, cmp_ctrl, ALUControl, md_start, md_op}), 32'd0);
    advance();
    inst_valid = 1'b0;
    sample();
    check("ffff.invalid", 32'(illegal), 32'd0);
    advance();

    // Flush in IDLE suppresses the start.
    inst = I_MUL; inst_valid = 1'b1; flush = 1'b1;
    sample();
    check_quiet("idle_flush");
    advance();
    flush = 1'b0; inst_valid = 1'b0;
    sample();
    check_quiet("idle_flush.next");
    advance();

    run_mop(I_MUL, 0, 1'b0, 1'b1);
    run_mop(I_DIV, 10, 1'b0, 1'b1);

    // Reset two cycles into a MUL aborts it with no completion.
    inst = I_MUL; inst_valid = 1'b1;
    sample();
    check("rstmul.md_start", 32'(md_start), 32'd1);
    advance();
    sample();
    check("rstmul.md_busy1", 32'(md_busy), 32'd1);
    advance();
    rst = 1'b1;
    sample();
    check("rstmul.md_busy2", 32'(md_busy), 32'd1);
    advance();
    rst = 1'b0; inst_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      check_quiet("rstmul.after");
      advance();
    end

    // Back-to-back M ops, then randomized latencies, flush points and held-inst changes.
    run_mop(I_MUL, 0, 1'b1, 1'b0);
    run_mop(I_DIV, 0, 1'b0, 1'b1);
    for (int n = 0; n < 12; n++) begin
      logic [31:0] w;
      int          lat, f;
      w      = $urandom;
      w[6:0] = 7'b0110011;
      w[31:25] = 7'h01;
      lat    = w[14] ? DIV_LAT : MUL_LAT;
      f      = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, lat + 1));
      run_mop(w, f, 1'($urandom_range(0, 1)), (f != 0) || ($urandom_range(0, 1) == 1));
    end
    inst_valid = 1'b0;
    advance();

    for (int n = 0; n < 300; n++) begin
      inst       = rand_inst();
      inst_valid = ($urandom_range(0, 7) != 0);
      cmp_res    = 1'($urandom_range(0, 1));
      sample();
      check_dec();
      check("rnd.stall", 32'(stall), 32'd0);
      check("rnd.md_op", 32'(md_op), 32'd0);
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
